// File: rtl/rx_logic.sv
// rx_logic: serial receive engine for the SSP frame format.
// Brings the peer's serial clock, frame sync and data into the PCLK domain,
// deserializes each frame MSB-first and pushes completed words to the RX FIFO.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for frame sync on a sample strobe; data line ignored
// SHIFT | collecting bits of a word; bit_cnt = bits accepted so far
module rx_logic #(
   parameter int SSP_WORD_SIZE = 8
) (
   input  logic                     PCLK,
   input  logic                     CLEAR_B,
   input  logic                     SSPCLKIN,
   input  logic                     SSPFSSIN,
   input  logic                     SSPRXD,
   input  logic                     FIFOFull,
   output logic [SSP_WORD_SIZE-1:0] RxData,
   output logic                     write,
   output logic                     OVERRUN,
   output logic                     FRAMEERR
);

   localparam int W  = SSP_WORD_SIZE;
   localparam int CW = $clog2(W);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state;
   logic [CW-1:0] bit_cnt;
   logic [W-2:0]  sr;

   logic clk_s1, clk_s2, clk_prev;
   logic fss_s1, fss_s2;
   logic rxd_s1, rxd_s2;
   logic strobe;
   logic last_bit;

   // Equal-depth synchronizers keep clock, sync and data aligned; clk_prev
   // adds one more stage on the clock path for falling-edge detection.
   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         clk_s1   <= 1'b0;
         clk_s2   <= 1'b0;
         clk_prev <= 1'b0;
         fss_s1   <= 1'b0;
         fss_s2   <= 1'b0;
         rxd_s1   <= 1'b0;
         rxd_s2   <= 1'b0;
      end else begin
         clk_s1   <= SSPCLKIN;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         fss_s1   <= SSPFSSIN;
         fss_s2   <= fss_s1;
         rxd_s1   <= SSPRXD;
         rxd_s2   <= rxd_s1;
      end
   end

   // Peer's falling edge: the point where data is stable and gets sampled.
   assign strobe   = clk_prev & ~clk_s2;
   assign last_bit = (bit_cnt == CW'(W - 1));

   // Frame FSM with registered FIFO push, data and sticky error flags.
   always_ff @(posedge PCLK or negedge CLEAR_B) begin
      if (!CLEAR_B) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         sr       <= '0;
         RxData   <= '0;
         write    <= 1'b0;
         OVERRUN  <= 1'b0;
         FRAMEERR <= 1'b0;
      end else begin
         write <= 1'b0;
         if (strobe) begin
            case (state)
               IDLE: begin
                  if (fss_s2) begin
                     state   <= SHIFT;
                     bit_cnt <= '0;
                     sr      <= '0;
                  end
               end
               SHIFT: begin
                  if (last_bit) begin
                     if (!FIFOFull) begin
                        RxData <= {sr, rxd_s2};
                        write  <= 1'b1;
                     end else begin
                        OVERRUN <= 1'b1;
                     end
                     bit_cnt <= '0;
                     sr      <= '0;
                     // Sync on the last bit opens the next frame with no gap.
                     state   <= fss_s2 ? SHIFT : IDLE;
                  end else if (fss_s2) begin
                     // Early sync: drop the partial word and start over.
                     FRAMEERR <= 1'b1;
                     bit_cnt  <= '0;
                     sr       <= '0;
                  end else begin
                     sr      <= {sr[W-3:0], rxd_s2};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_logic.sv
// Testbench for rx_logic: drives SSP frames at PCLK/4 and compares the pushed
// words and sticky flags against a frame-level reference model.
module tb_rx_logic;

   localparam int W = 8;

   logic         PCLK     = 1'b0;
   logic         CLEAR_B  = 1'b0;
   logic         SSPCLKIN = 1'b1;
   logic         SSPFSSIN = 1'b0;
   logic         SSPRXD   = 1'b0;
   logic         FIFOFull = 1'b0;
   logic [W-1:0] RxData;
   logic         write;
   logic         OVERRUN;
   logic         FRAMEERR;

   int n_checks  = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int last_fall = 0;

   // reference model state: frame-level view of the receiver
   bit           m_in_frame;
   int           m_nbits;
   logic [W-1:0] m_acc;
   bit           m_ovr;
   bit           m_ferr;
   logic [W-1:0] m_rx;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int           wcyc_q[$];

   rx_logic #(.SSP_WORD_SIZE(W)) dut (
      .PCLK     (PCLK),
      .CLEAR_B  (CLEAR_B),
      .SSPCLKIN (SSPCLKIN),
      .SSPFSSIN (SSPFSSIN),
      .SSPRXD   (SSPRXD),
      .FIFOFull (FIFOFull),
      .RxData   (RxData),
      .write    (write),
      .OVERRUN  (OVERRUN),
      .FRAMEERR (FRAMEERR)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) cyc++;

   always @(negedge PCLK) begin
      if (write === 1'b1) begin
         got_q.push_back(RxData);
         wcyc_q.push_back(cyc);
      end
   end

   task automatic model_reset();
      m_in_frame = 0;
      m_nbits    = 0;
      m_acc      = '0;
      m_ovr      = 0;
      m_ferr     = 0;
      m_rx       = '0;
      exp_q.delete();
      got_q.delete();
      wcyc_q.delete();
   endtask

   // One sampled serial period: a frame is a sync period followed by W data
   // bits; sync before W bits is an error, sync on the last bit chains frames.
   task automatic model_step(input bit fss, input bit rxd, input bit full);
      if (!m_in_frame) begin
         if (fss) begin
            m_in_frame = 1;
            m_nbits    = 0;
            m_acc      = '0;
         end
      end else if (m_nbits == W - 1) begin
         m_acc = {m_acc[W-2:0], rxd};
         if (full) m_ovr = 1;
         else begin
            exp_q.push_back(m_acc);
            m_rx = m_acc;
         end
         m_in_frame = fss;
         m_nbits    = 0;
         m_acc      = '0;
      end else if (fss) begin
         m_ferr  = 1;
         m_nbits = 0;
         m_acc   = '0;
      end else begin
         m_acc   = {m_acc[W-2:0], rxd};
         m_nbits = m_nbits + 1;
      end
   endtask

   task automatic send_period(input bit fss, input bit rxd, input bit full);
      @(negedge PCLK);
      SSPCLKIN = 1'b1;
      SSPFSSIN = fss;
      SSPRXD   = rxd;
      @(negedge PCLK);
      @(negedge PCLK);
      SSPCLKIN  = 1'b0;
      FIFOFull  = full;
      last_fall = cyc + 1;
      @(negedge PCLK);
      model_step(fss, rxd, full);
   endtask

   task automatic send_sync();
      send_period(1'b1, 1'($urandom_range(0, 1)), 1'b0);
   endtask

   task automatic send_frame(input logic [W-1:0] word, input bit full, input bit b2b);
      for (int i = W - 1; i >= 0; i--)
         send_period((i == 0) ? b2b : 1'b0, word[i], full);
   endtask

   task automatic idle(input int n);
      @(negedge PCLK);
      SSPCLKIN = 1'b1;
      SSPFSSIN = 1'b0;
      repeat (n) @(negedge PCLK);
   endtask

   task automatic apply_reset();
      @(negedge PCLK);
      CLEAR_B  = 1'b0;
      SSPCLKIN = 1'b1;
      SSPFSSIN = 1'b0;
      FIFOFull = 1'b0;
      repeat (3) @(negedge PCLK);
      CLEAR_B = 1'b1;
      repeat (2) @(negedge PCLK);
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks += 4;
      if (RxData !== '0)    begin n_fail++; $display("FAIL reset_rxdata got %h want 00", RxData); end
      if (write !== 1'b0)   begin n_fail++; $display("FAIL reset_write got %b want 0", write); end
      if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", OVERRUN); end
      if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL reset_frameerr got %b want 0", FRAMEERR); end
   endtask

   task automatic test_single();
      int lat;
      apply_reset();
      send_sync();
      send_frame(8'hA5, 1'b0, 1'b0);
      idle(8);
      n_checks += 5;
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL single_count got %0d want 1", got_q.size());
      end else begin
         lat = wcyc_q[0] - last_fall;
         if (got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", got_q[0]); end
         if (lat !== 2) begin n_fail++; $display("FAIL single_latency got %0d want 2", lat); end
      end
      if (OVERRUN !== 1'b0)  begin n_fail++; $display("FAIL single_overrun got %b want 0", OVERRUN); end
      if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL single_frameerr got %b want 0", FRAMEERR); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] want[3];
      want = '{8'h3C, 8'hC3, 8'hFF};
      apply_reset();
      send_sync();
      send_frame(want[0], 1'b0, 1'b1);
      send_frame(want[1], 1'b0, 1'b1);
      send_frame(want[2], 1'b0, 1'b0);
      idle(8);
      n_checks++;
      if (got_q.size() !== 3) begin
         n_fail++; $display("FAIL b2b_count got %0d want 3", got_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got_q[i] !== want[i]) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, got_q[i], want[i]); end
         end
         for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (wcyc_q[i] - wcyc_q[i-1] !== 4 * W) begin
               n_fail++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, wcyc_q[i] - wcyc_q[i-1], 4 * W);
            end
         end
      end
      n_checks++;
      if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL b2b_frameerr got %b want 0", FRAMEERR); end
   endtask

   task automatic test_overrun();
      apply_reset();
      send_sync();
      send_frame(8'h77, 1'b0, 1'b0);
      send_sync();
      send_frame(8'h12, 1'b1, 1'b0);
      idle(8);
      FIFOFull = 1'b0;
      n_checks += 3;
      if (got_q.size() !== 1) begin n_fail++; $display("FAIL ovr_count1 got %0d want 1", got_q.size()); end
      if (RxData !== 8'h77)   begin n_fail++; $display("FAIL ovr_hold got %h want 77", RxData); end
      if (OVERRUN !== 1'b1)   begin n_fail++; $display("FAIL ovr_flag got %b want 1", OVERRUN); end
      send_sync();
      send_frame(8'h34, 1'b0, 1'b0);
      idle(8);
      n_checks += 3;
      if (got_q.size() !== 2) begin
         n_fail++; $display("FAIL ovr_count2 got %0d want 2", got_q.size());
      end else if (got_q[1] !== 8'h34) begin
         n_fail++; $display("FAIL ovr_data2 got %h want 34", got_q[1]);
      end
      if (OVERRUN !== 1'b1)  begin n_fail++; $display("FAIL ovr_sticky got %b want 1", OVERRUN); end
      if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL ovr_frameerr got %b want 0", FRAMEERR); end
   endtask

   task automatic test_frame_err();
      apply_reset();
      send_sync();
      for (int i = 0; i < 4; i++) send_period(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      send_sync();
      send_frame(8'h81, 1'b0, 1'b0);
      idle(8);
      n_checks += 3;
      if (FRAMEERR !== 1'b1) begin n_fail++; $display("FAIL ferr_flag got %b want 1", FRAMEERR); end
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL ferr_count got %0d want 1", got_q.size());
      end else if (got_q[0] !== 8'h81) begin
         n_fail++; $display("FAIL ferr_data got %h want 81", got_q[0]);
      end
      if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL ferr_overrun got %b want 0", OVERRUN); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      send_sync();
      send_frame(8'hC3, 1'b0, 1'b0);
      send_sync();
      send_frame(8'h11, 1'b1, 1'b0);
      send_sync();
      for (int i = 0; i < 5; i++) send_period(1'b0, 1'b1, 1'b0);
      @(negedge PCLK);
      #2 CLEAR_B = 1'b0;
      #1;
      n_checks += 4;
      if (RxData !== '0)     begin n_fail++; $display("FAIL mrst_rxdata got %h want 00", RxData); end
      if (write !== 1'b0)    begin n_fail++; $display("FAIL mrst_write got %b want 0", write); end
      if (OVERRUN !== 1'b0)  begin n_fail++; $display("FAIL mrst_overrun got %b want 0", OVERRUN); end
      if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL mrst_frameerr got %b want 0", FRAMEERR); end
      SSPCLKIN = 1'b1;
      FIFOFull = 1'b0;
      repeat (2) @(negedge PCLK);
      CLEAR_B = 1'b1;
      model_reset();
      repeat (2) @(negedge PCLK);
      send_sync();
      send_frame(8'h5A, 1'b0, 1'b0);
      idle(8);
      n_checks += 2;
      if (got_q.size() !== 1) begin
         n_fail++; $display("FAIL mrst_count got %0d want 1", got_q.size());
      end else if (got_q[0] !== 8'h5A) begin
         n_fail++; $display("FAIL mrst_data got %h want 5a", got_q[0]);
      end
      if (FRAMEERR !== 1'b0) begin n_fail++; $display("FAIL mrst_ferr_after got %b want 0", FRAMEERR); end
   endtask

   task automatic test_no_fss();
      apply_reset();
      for (int i = 0; i < 3 * W; i++) send_period(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle(8);
      FIFOFull = 1'b0;
      n_checks += 4;
      if (got_q.size() !== 0) begin n_fail++; $display("FAIL nofss_count got %0d want 0", got_q.size()); end
      if (RxData !== '0)      begin n_fail++; $display("FAIL nofss_rxdata got %h want 00", RxData); end
      if (OVERRUN !== 1'b0)   begin n_fail++; $display("FAIL nofss_overrun got %b want 0", OVERRUN); end
      if (FRAMEERR !== 1'b0)  begin n_fail++; $display("FAIL nofss_frameerr got %b want 0", FRAMEERR); end
   endtask

   task automatic test_random();
      logic [W-1:0] word;
      bit           chained;
      int           glitch;
      for (int run = 0; run < 4; run++) begin
         apply_reset();
         chained = 0;
         for (int f = 0; f < 8; f++) begin
            word = W'($urandom);
            if (!chained) begin
               for (int g = $urandom_range(0, 2); g > 0; g--)
                  send_period(1'b0, 1'($urandom_range(0, 1)), 1'b0);
               send_sync();
            end
            glitch = ($urandom_range(0, 5) == 0) ? $urandom_range(0, W - 2) : -1;
            if (glitch >= 0) begin
               for (int i = 0; i < glitch; i++) send_period(1'b0, 1'($urandom_range(0, 1)), 1'b0);
               send_sync();
            end
            chained = ($urandom_range(0, 2) == 0);
            send_frame(word, ($urandom_range(0, 4) == 0), chained);
         end
         idle(8);
         FIFOFull = 1'b0;
         n_checks += 4;
         if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rand%0d_count got %0d want %0d", run, got_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               n_checks++;
               if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand%0d_data%0d got %h want %h", run, i, got_q[i], exp_q[i]); end
            end
         end
         if (RxData !== m_rx)     begin n_fail++; $display("FAIL rand%0d_rxdata got %h want %h", run, RxData, m_rx); end
         if (OVERRUN !== m_ovr)   begin n_fail++; $display("FAIL rand%0d_overrun got %b want %b", run, OVERRUN, m_ovr); end
         if (FRAMEERR !== m_ferr) begin n_fail++; $display("FAIL rand%0d_frameerr got %b want %b", run, FRAMEERR, m_ferr); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_overrun();
      test_frame_err();
      test_mid_reset();
      test_no_fss();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
